reward_scheduler: RTL
=====================

// Module: reward_scheduler
// PURPOSE
//  Transmit-side scheduler for the reward packer.
//  - Collects packet-send requests from received packets, role changes, local data/energy
//    flags and two cluster-formation timers.
//  - Arbitrates the requests by fixed priority and sequences the reward block (en -> reward_done).
//  - Hands each packed packet to the radio via a req/ack handshake.
//  - Sits between packetFilter/MY_NODE_INFO and reward; owns HB de-duplication and the MR/CHT timeouts.
// PARAMETERS
//  WORD_WIDTH    16  width of hop/count fields
//  MAX_CH_HOPS   4   INV rippled only if ev_hops_from_ch < MAX_CH_HOPS
//  MR_TIMEOUT    15  cycles from first INV (non-CH) to MR request
//  CHT_TIMEOUT   15  cycles from becoming CH to CHT request
//  WDOG_CYCLES   8   max cycles waiting for rw_done before abort
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous reset, active-high
//  ev_valid         in   1   1-cycle strobe: filtered packet received
//  ev_type          in   3   packet type of received packet (HB=000..SOS=110)
//  ev_hops_from_ch  in   WW  hopsFromCH field of received packet
//  i_am_destination in   1   received packet addressed to this node (qualified by ev_valid)
//  role             in   1   1 = cluster head
//  i_have_data      in   1   local data ready (level)
//  low_e            in   1   energy below threshold (level)
//  rw_en            out  1   1-cycle start pulse to reward block
//  rw_pkt_type      out  3   packet type to pack; 3'b111 = none
//  rw_done          in   1   reward block finished packing
//  tx_req           out  1   packed packet ready for radio; held until tx_ack
//  tx_ack           in   1   radio accepted packet
//  busy             out  1   FSM not in S_IDLE
//  pending          out  6   request flags {SOS,DATA,MR,CHT,INV,HB}
//  err_wdog         out  1   1-cycle pulse: rw_done watchdog expired
// BEHAVIOUR
//  Reset values: rw_en=0, rw_pkt_type=3'b111, tx_req=0, busy=0, pending=0, err_wdog=0.
//  Reset also clears hb_lock and both timers; any transaction in flight is abandoned.
//  Request sources: each sets its pending bit at the edge after the event.
//  - HB:   ev_valid & ev_type==000 & !hb_lock. Also sets hb_lock. HB while locked is ignored.
//  - hb_lock clear: ev_valid & ev_type==101.
//  - INV:  ev_valid & ev_type==010 & ev_hops_from_ch<MAX_CH_HOPS & !role; also set on role 0->1.
//  - MR timer:
//    - Load MR_TIMEOUT on the first qualifying INV (any hops, !role) while the MR timer is idle.
//    - Decrements by 1 per cycle; on reaching 0, set MR and return to idle.
//    - Role 0->1 cancels the MR timer.
//  - CHT timer: load CHT_TIMEOUT on role 0->1; decrements by 1 per cycle; on reaching 0, set CHT.
//  - DATA: (ev_valid & ev_type==101 & i_am_destination) | i_have_data 0->1.
//  - SOS:  (ev_valid & ev_type==110 & i_am_destination) | low_e 0->1.
//  - Coalescing: repeat requests while a bit is already set coalesce into that one bit.
//  Priority (high->low): HB > INV > CHT > MR > SOS > DATA.
//  FSM:
//  - S_IDLE: if pending!=0, latch the winner into rw_pkt_type, clear that bit, go to S_ARM.
//  - S_ARM: rw_en=1 for exactly this cycle; go to S_WAIT.
//  - S_WAIT:
//    - rw_done=1 -> S_TX.
//    - No rw_done within WDOG_CYCLES cycles -> err_wdog pulse, request dropped, rw_pkt_type=111, S_IDLE.
//  - S_TX:
//    - tx_req=1 until the cycle tx_ack=1.
//    - Then rw_pkt_type=111 and go to S_IDLE.
//    - tx_ack is ignored outside S_TX.
//  Latency: event at cycle 0 -> pending at 1 -> S_ARM/rw_en at 2 -> earliest tx_req at 4.
//  Simultaneous set and grant-clear of the same bit: set wins (bit stays 1).
//  No new grant while busy; requests keep accumulating in pending.
//  Timer width is WORD_WIDTH; countdown saturates at 0 (no wrap).
//  Timer reload while already counting is ignored.
// TESTING
//  1 HB at cyc 0, rw_done at cyc 4, tx_ack at cyc 6:
//    -> rw_en@2 with type 000; tx_req cycles 5-6; second HB ignored until a DATA pkt is received.
//  2 INV with hops=3, then hops=4:
//    -> one INV (010) send only.
//    -> 15 cycles after the first INV: MR (011) request issued.
//  3 role 0->1:
//    -> INV (010) sent.
//    -> CHT (100) pending exactly 15 cycles later.
//    -> a running MR timer never fires.
//  4 HB, INV and SOS on the same cycle:
//    -> grants in order 000, 010, 110; pending bits clear one per transaction.
//  5 rw_done never asserted:
//    -> err_wdog pulses 8 cycles after S_WAIT entry; FSM to S_IDLE; rw_pkt_type=111.
//  6 rst asserted in S_TX with pending=6'b100001:
//    -> next cycle all outputs at reset values; hb_lock=0.

Source files
------------

// File: rtl/reward_scheduler.sv
// Transmit-side scheduler for the reward packer: gathers send requests,
// arbitrates them by fixed priority, sequences the reward block and hands
// each packed packet to the radio over a req/ack handshake.
module reward_scheduler #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned MAX_CH_HOPS = 4,
  parameter int unsigned MR_TIMEOUT  = 15,
  parameter int unsigned CHT_TIMEOUT = 15,
  parameter int unsigned WDOG_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ev_valid,
  input  logic [2:0]            ev_type,
  input  logic [WORD_WIDTH-1:0] ev_hops_from_ch,
  input  logic                  i_am_destination,
  input  logic                  role,
  input  logic                  i_have_data,
  input  logic                  low_e,
  output logic                  rw_en,
  output logic [2:0]            rw_pkt_type,
  input  logic                  rw_done,
  output logic                  tx_req,
  input  logic                  tx_ack,
  output logic                  busy,
  output logic [5:0]            pending,
  output logic                  err_wdog
);

  localparam int unsigned WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  // Packet type codes
  localparam logic [2:0] T_HB   = 3'b000;
  localparam logic [2:0] T_INV  = 3'b010;
  localparam logic [2:0] T_MR   = 3'b011;
  localparam logic [2:0] T_CHT  = 3'b100;
  localparam logic [2:0] T_DATA = 3'b101;
  localparam logic [2:0] T_SOS  = 3'b110;
  localparam logic [2:0] T_NONE = 3'b111;

  // Bit positions inside pending = {SOS,DATA,MR,CHT,INV,HB}
  localparam int unsigned B_HB   = 0;
  localparam int unsigned B_INV  = 1;
  localparam int unsigned B_CHT  = 2;
  localparam int unsigned B_MR   = 3;
  localparam int unsigned B_DATA = 4;
  localparam int unsigned B_SOS  = 5;

  // FSM states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_TX   = 2'd3;

  logic [1:0]            r_state;
  logic [5:0]            r_pending;
  logic [2:0]            r_pkt_type;
  logic                  r_rw_en;
  logic                  r_tx_req;
  logic                  r_busy;
  logic                  r_err_wdog;
  logic [WDOG_W-1:0]     r_wdog_cnt;
  logic                  r_hb_lock;
  logic [WORD_WIDTH-1:0] r_mr_cnt;
  logic [WORD_WIDTH-1:0] r_cht_cnt;
  logic                  r_role_d;
  logic                  r_data_d;
  logic                  r_low_e_d;

  logic                  w_hb_ev;
  logic                  w_inv_any;
  logic                  w_inv_ev;
  logic                  w_role_rise;
  logic                  w_data_rise;
  logic                  w_low_e_rise;
  logic                  w_mr_fire;
  logic                  w_cht_fire;
  logic [5:0]            w_set;
  logic                  w_hb_lock_nxt;
  logic [WORD_WIDTH-1:0] w_mr_nxt;
  logic [WORD_WIDTH-1:0] w_cht_nxt;
  logic [5:0]            w_win_mask;
  logic [2:0]            w_win_type;
  logic [1:0]            w_state_nxt;
  logic [5:0]            w_grant_mask;
  logic [5:0]            w_pending_nxt;
  logic [2:0]            w_pkt_type_nxt;
  logic                  w_rw_en_nxt;
  logic                  w_tx_req_nxt;
  logic                  w_err_nxt;
  logic [WDOG_W-1:0]     w_wdog_nxt;

  // Edge detectors track their inputs through reset so a level already high
  // when reset releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    r_role_d  <= role;
    r_data_d  <= i_have_data;
    r_low_e_d <= low_e;
  end

  // Decode received packets and local level changes into request strobes.
  always_comb begin
    w_hb_ev      = ev_valid && (ev_type == T_HB) && !r_hb_lock;
    w_inv_any    = ev_valid && (ev_type == T_INV) && !role;
    w_inv_ev     = w_inv_any && (ev_hops_from_ch < WORD_WIDTH'(MAX_CH_HOPS));
    w_role_rise  = role && !r_role_d;
    w_data_rise  = i_have_data && !r_data_d;
    w_low_e_rise = low_e && !r_low_e_d;
    // Becoming CH cancels the member-side MR timer, even on its final cycle.
    w_mr_fire    = (r_mr_cnt == WORD_WIDTH'(1)) && !w_role_rise;
    w_cht_fire   = (r_cht_cnt == WORD_WIDTH'(1));

    w_set         = '0;
    w_set[B_HB]   = w_hb_ev;
    w_set[B_INV]  = w_inv_ev || w_role_rise;
    w_set[B_CHT]  = w_cht_fire;
    w_set[B_MR]   = w_mr_fire;
    w_set[B_DATA] = (ev_valid && (ev_type == T_DATA) && i_am_destination) || w_data_rise;
    w_set[B_SOS]  = (ev_valid && (ev_type == T_SOS) && i_am_destination) || w_low_e_rise;

    // A received DATA packet re-opens heartbeat forwarding.
    w_hb_lock_nxt = r_hb_lock;
    if (w_hb_ev) begin
      w_hb_lock_nxt = 1'b1;
    end else if (ev_valid && (ev_type == T_DATA)) begin
      w_hb_lock_nxt = 1'b0;
    end
  end

  // MR/CHT countdowns: zero means idle, loads while counting are ignored.
  always_comb begin
    w_mr_nxt = r_mr_cnt;
    if (w_role_rise) begin
      w_mr_nxt = '0;
    end else if (r_mr_cnt != '0) begin
      w_mr_nxt = r_mr_cnt - WORD_WIDTH'(1);
    end else if (w_inv_any) begin
      w_mr_nxt = WORD_WIDTH'(MR_TIMEOUT);
    end

    w_cht_nxt = r_cht_cnt;
    if (r_cht_cnt != '0) begin
      w_cht_nxt = r_cht_cnt - WORD_WIDTH'(1);
    end else if (w_role_rise) begin
      w_cht_nxt = WORD_WIDTH'(CHT_TIMEOUT);
    end
  end

  // Fixed-priority pick among pending requests: HB > INV > CHT > MR > SOS > DATA.
  always_comb begin
    w_win_mask = '0;
    w_win_type = T_NONE;
    if (r_pending[B_HB]) begin
      w_win_mask[B_HB] = 1'b1;
      w_win_type       = T_HB;
    end else if (r_pending[B_INV]) begin
      w_win_mask[B_INV] = 1'b1;
      w_win_type        = T_INV;
    end else if (r_pending[B_CHT]) begin
      w_win_mask[B_CHT] = 1'b1;
      w_win_type        = T_CHT;
    end else if (r_pending[B_MR]) begin
      w_win_mask[B_MR] = 1'b1;
      w_win_type       = T_MR;
    end else if (r_pending[B_SOS]) begin
      w_win_mask[B_SOS] = 1'b1;
      w_win_type        = T_SOS;
    end else if (r_pending[B_DATA]) begin
      w_win_mask[B_DATA] = 1'b1;
      w_win_type         = T_DATA;
    end
  end

  // Transaction sequencer: grant, start the packer, wait for it, hand to radio.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_mask   = '0;
    w_pkt_type_nxt = r_pkt_type;
    w_rw_en_nxt    = 1'b0;
    w_tx_req_nxt   = 1'b0;
    w_err_nxt      = 1'b0;
    w_wdog_nxt     = r_wdog_cnt;

    case (r_state)
      S_IDLE: begin
        if (r_pending != '0) begin
          w_grant_mask   = w_win_mask;
          w_pkt_type_nxt = w_win_type;
          w_rw_en_nxt    = 1'b1;
          w_state_nxt    = S_ARM;
        end
      end
      S_ARM: begin
        w_wdog_nxt  = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rw_done) begin
          w_tx_req_nxt = 1'b1;
          w_state_nxt  = S_TX;
        end else if (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
          // Packer never answered: drop this request and report it.
          w_err_nxt      = 1'b1;
          w_pkt_type_nxt = T_NONE;
          w_state_nxt    = S_IDLE;
        end else begin
          w_wdog_nxt = r_wdog_cnt + WDOG_W'(1);
        end
      end
      S_TX: begin
        if (tx_ack) begin
          w_pkt_type_nxt = T_NONE;
          w_state_nxt    = S_IDLE;
        end else begin
          w_tx_req_nxt = 1'b1;
        end
      end
      default: begin
        w_pkt_type_nxt = T_NONE;
        w_state_nxt    = S_IDLE;
      end
    endcase

    // A new request for the bit being granted this cycle survives the clear.
    w_pending_nxt = (r_pending & ~w_grant_mask) | w_set;
  end

  // State, request and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_pkt_type <= T_NONE;
      r_rw_en    <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
      r_err_wdog <= 1'b0;
      r_wdog_cnt <= '0;
      r_hb_lock  <= 1'b0;
      r_mr_cnt   <= '0;
      r_cht_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_pkt_type <= w_pkt_type_nxt;
      r_rw_en    <= w_rw_en_nxt;
      r_tx_req   <= w_tx_req_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_err_wdog <= w_err_nxt;
      r_wdog_cnt <= w_wdog_nxt;
      r_hb_lock  <= w_hb_lock_nxt;
      r_mr_cnt   <= w_mr_nxt;
      r_cht_cnt  <= w_cht_nxt;
    end
  end

  assign rw_en       = r_rw_en;
  assign rw_pkt_type = r_pkt_type;
  assign tx_req      = r_tx_req;
  assign busy        = r_busy;
  assign pending     = r_pending;
  assign err_wdog    = r_err_wdog;

endmodule
